// File: rtl/xy_lane_dispatch.sv
// xy_lane_dispatch: round-robin fan-out of x/y pairs to four lanes, each with a
// one-entry output register. A lane-order FIFO records the dispatch order so a
// downstream 4:1 select can recombine results in arrival order.
module xy_lane_dispatch #(
    parameter int unsigned W           = 19,
    parameter int unsigned ORDER_DEPTH = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [W-1:0] x0_out,
    output logic [W-1:0] x1_out,
    output logic [W-1:0] x2_out,
    output logic [W-1:0] x3_out,
    output logic [W-1:0] y0_out,
    output logic [W-1:0] y1_out,
    output logic [W-1:0] y2_out,
    output logic [W-1:0] y3_out,
    output logic         valid0_out,
    output logic         valid1_out,
    output logic         valid2_out,
    output logic         valid3_out,
    input  logic         ready0_in,
    input  logic         ready1_in,
    input  logic         ready2_in,
    input  logic         ready3_in,
    output logic [1:0]   sel_out,
    output logic         sel_valid_out,
    input  logic         sel_ready_in
);

    localparam int unsigned AW = $clog2(ORDER_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]    ptr;
    logic [3:0]    full;
    logic [3:0]    lane_rdy;
    logic [W-1:0]  xr [4];
    logic [W-1:0]  yr [4];

    logic [1:0]    mem [ORDER_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    sel_q;

    logic          accept;
    logic          pop;

    assign lane_rdy = {ready3_in, ready2_in, ready1_in, ready0_in};

    assign sel_valid_out = (count != '0);
    assign sel_out       = sel_q;
    assign pop           = sel_valid_out && sel_ready_in;

    // Stall on the pointed-to lane only (strict order); a pop frees a slot for a push.
    assign ready_out = (!full[ptr] || lane_rdy[ptr]) &&
                       ((count < CW'(ORDER_DEPTH)) || pop);
    assign accept    = valid_in && ready_out;

    assign x0_out = xr[0];
    assign x1_out = xr[1];
    assign x2_out = xr[2];
    assign x3_out = xr[3];
    assign y0_out = yr[0];
    assign y1_out = yr[1];
    assign y2_out = yr[2];
    assign y3_out = yr[3];
    assign valid0_out = full[0];
    assign valid1_out = full[1];
    assign valid2_out = full[2];
    assign valid3_out = full[3];

    // Next read pointer and occupancy of the order FIFO.
    always_comb begin
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Lane registers: load on dispatch to this lane, clear full flag on drain.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            full <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                xr[k] <= '0;
                yr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (accept && ptr == 2'(k)) begin
                    full[k] <= 1'b1;
                    xr[k]   <= x_in;
                    yr[k]   <= y_in;
                end else if (full[k] && lane_rdy[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    // Order FIFO storage; contents are don't-care while not counted.
    always_ff @(posedge clk_in) begin
        if (!rst_in && accept) begin
            mem[wr_ptr] <= ptr;
        end
    end

    // Round-robin pointer, FIFO pointers/count and registered head.
    // The head register is loaded with the entry that will be at the front after
    // this edge, bypassing the write when that entry is the one being pushed, so
    // sel_out holds its last value once the FIFO empties.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sel_q  <= '0;
        end else begin
            if (accept) begin
                ptr    <= ptr + 2'd1;
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                sel_q <= (accept && wr_ptr == rd_next) ? ptr : mem[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_xy_lane_dispatch.sv
// Scoreboard bench for xy_lane_dispatch: stimulus pushes expected lane data and
// lane-order indices; a negedge monitor pops and compares on every handshake.
module tb_xy_lane_dispatch;

    localparam int unsigned W = 19;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [W-1:0] x_in, y_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] x0_out, x1_out, x2_out, x3_out;
    logic [W-1:0] y0_out, y1_out, y2_out, y3_out;
    logic         valid0_out, valid1_out, valid2_out, valid3_out;
    logic         ready0_in, ready1_in, ready2_in, ready3_in;
    logic [1:0]   sel_out;
    logic         sel_valid_out;
    logic         sel_ready_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] lane_q [4][$];
    logic [1:0]     sel_q [$];
    logic [1:0]     mptr;

    logic [3:0]   vld, rdy;
    logic [W-1:0] xo [4];
    logic [W-1:0] yo [4];

    assign vld = {valid3_out, valid2_out, valid1_out, valid0_out};
    assign rdy = {ready3_in, ready2_in, ready1_in, ready0_in};
    assign xo[0] = x0_out;
    assign xo[1] = x1_out;
    assign xo[2] = x2_out;
    assign xo[3] = x3_out;
    assign yo[0] = y0_out;
    assign yo[1] = y1_out;
    assign yo[2] = y2_out;
    assign yo[3] = y3_out;

    xy_lane_dispatch #(.W(W), .ORDER_DEPTH(8)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .x_in(x_in), .y_in(y_in), .valid_in(valid_in), .ready_out(ready_out),
        .x0_out(x0_out), .x1_out(x1_out), .x2_out(x2_out), .x3_out(x3_out),
        .y0_out(y0_out), .y1_out(y1_out), .y2_out(y2_out), .y3_out(y3_out),
        .valid0_out(valid0_out), .valid1_out(valid1_out),
        .valid2_out(valid2_out), .valid3_out(valid3_out),
        .ready0_in(ready0_in), .ready1_in(ready1_in),
        .ready2_in(ready2_in), .ready3_in(ready3_in),
        .sel_out(sel_out), .sel_valid_out(sel_valid_out), .sel_ready_in(sel_ready_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every lane drain and every order pop is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_in === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k] && rdy[k]) begin
                    if (lane_q[k].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL lane%0d_unexpected: got x=%0d y=%0d expected no pair", k, xo[k], yo[k]);
                    end else begin
                        check($sformatf("lane%0d_xy", k), 64'({xo[k], yo[k]}), 64'(lane_q[k].pop_front()));
                    end
                end
            end
            if (sel_valid_out && sel_ready_in) begin
                if (sel_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sel_unexpected: got sel=%0d expected no entry", sel_out);
                end else begin
                    check("sel_order", 64'(sel_out), 64'(sel_q.pop_front()));
                end
            end
        end
    end

    task automatic offer(input int x, input int y);
        valid_in = 1'b1;
        x_in     = W'(x);
        y_in     = W'(y);
    endtask

    // One cycle of an offered pair: check ready, record the accept, check latency.
    task automatic step(input logic exp_rdy, input string name);
        logic       acc;
        logic [1:0] lane;
        @(negedge clk);
        check({name, "_ready"}, 64'(ready_out), 64'(exp_rdy));
        acc  = valid_in && ready_out;
        lane = mptr;
        if (acc) begin
            lane_q[lane].push_back({x_in, y_in});
            sel_q.push_back(lane);
            mptr = mptr + 2'd1;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            check({name, "_valid"}, 64'(vld[lane]), 64'(1));
            check({name, "_data"}, 64'({xo[lane], yo[lane]}), 64'({x_in, y_in}));
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valids"}, 64'(vld), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_xy%0d", name, k), 64'({xo[k], yo[k]}), 64'(0));
        end
        check({name, "_sel_valid"}, 64'(sel_valid_out), 64'(0));
        check({name, "_sel"}, 64'(sel_out), 64'(0));
        check({name, "_ready"}, 64'(ready_out), 64'(1));
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        check({name, "_lane_q"}, 64'(lane_q[0].size() + lane_q[1].size() +
                                     lane_q[2].size() + lane_q[3].size()), 64'(0));
        check({name, "_sel_q"}, 64'(sel_q.size()), 64'(0));
        check({name, "_valids"}, 64'(vld), 64'(0));
        check({name, "_sel_valid"}, 64'(sel_valid_out), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        valid_in = 1'b0;
        x_in = '0;
        y_in = '0;
        {ready3_in, ready2_in, ready1_in, ready0_in} = 4'hf;
        sel_ready_in = 1'b1;
        mptr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        check_reset_state("reset");

        // Back-to-back stream, everything ready: lanes 0..3 twice, ready always 1.
        for (int i = 0; i < 8; i++) begin
            offer(i, 100 + i);
            step(1'b1, $sformatf("bb%0d", i));
        end
        idle(4);
        check_drained("bb_end");

        // Lane 1 stalled: pairs 0..4 flow, pair 5 waits for lane 1 to drain.
        ready1_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(20 + i, 200 + i);
            step(1'b1, $sformatf("l1stall%0d", i));
        end
        offer(25, 205);
        step(1'b0, "l1wait0");
        step(1'b0, "l1wait1");
        ready1_in = 1'b1;
        step(1'b1, "l1reload");
        idle(4);
        check_drained("l1_end");

        // Order FIFO fills to 8; a single pop admits exactly one more pair.
        sel_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            offer(40 + i, 300 + i);
            step(1'b1, $sformatf("fill%0d", i));
        end
        offer(48, 308);
        step(1'b0, "full0");
        step(1'b0, "full1");
        sel_ready_in = 1'b1;
        step(1'b1, "pushpop");
        sel_ready_in = 1'b0;
        offer(49, 309);
        step(1'b0, "full2");
        valid_in = 1'b0;
        sel_ready_in = 1'b1;
        idle(12);
        check_drained("fill_end");

        // Single pair through an empty FIFO: one-cycle sel_valid, head value held.
        offer(77, 777);
        step(1'b1, "single");
        valid_in = 1'b0;
        check("single_sel_valid", 64'(sel_valid_out), 64'(1));
        check("single_sel", 64'(sel_out), 64'(3));
        @(posedge clk);
        #1;
        check("single_sel_valid_after", 64'(sel_valid_out), 64'(0));
        check("single_sel_hold", 64'(sel_out), 64'(3));
        idle(2);
        check_drained("single_end");

        // Mid-stream reset with lanes 0..2 full and three order entries pending.
        {ready3_in, ready2_in, ready1_in, ready0_in} = 4'h0;
        sel_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(90 + i, 400 + i);
            step(1'b1, $sformatf("pre_rst%0d", i));
        end
        check("pre_rst_valids", 64'(vld), 64'(4'b0111));
        check("pre_rst_sel_valid", 64'(sel_valid_out), 64'(1));
        rst_in = 1'b1;
        offer(123, 456);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) lane_q[k].delete();
        sel_q.delete();
        mptr = 2'd0;
        check_reset_state("midrst");
        {ready3_in, ready2_in, ready1_in, ready0_in} = 4'hf;
        sel_ready_in = 1'b1;
        offer(5, 55);
        step(1'b1, "post_rst");
        check("post_rst_lane0", 64'(vld), 64'(4'b0001));
        idle(4);
        check_drained("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
